// File: rtl/ddc_pkg.sv
// Shared widths, CIC sizing and the quarter-wave sine table for the down-converter.
package ddc_pkg;
    localparam int PHASE_W = 32;
    localparam int LUT_AW  = 8;
    localparam int ADC_W   = 12;
    localparam int MIX_W   = 16;
    localparam int CIC_N   = 3;
    localparam int CIC_R   = 64;

    typedef enum logic {PTR_I = 1'b0, PTR_Q = 1'b1} ptr_e;

    function automatic int cic_width(input int n, input int r);
        return MIX_W + n * $clog2(r);
    endfunction

    localparam int CIC_W = cic_width(CIC_N, CIC_R);
    localparam int DEC_W = $clog2(CIC_R);

    // round(2047*sin(2*pi*k/256)) for k = 0..64
    function automatic logic [10:0] quarter_sine(input logic [6:0] k);
        logic [10:0] v;
        case (k)
            7'd0:  v = 11'd0;    7'd1:  v = 11'd50;   7'd2:  v = 11'd100;  7'd3:  v = 11'd151;
            7'd4:  v = 11'd201;  7'd5:  v = 11'd251;  7'd6:  v = 11'd300;  7'd7:  v = 11'd350;
            7'd8:  v = 11'd399;  7'd9:  v = 11'd449;  7'd10: v = 11'd497;  7'd11: v = 11'd546;
            7'd12: v = 11'd594;  7'd13: v = 11'd642;  7'd14: v = 11'd690;  7'd15: v = 11'd737;
            7'd16: v = 11'd783;  7'd17: v = 11'd830;  7'd18: v = 11'd875;  7'd19: v = 11'd920;
            7'd20: v = 11'd965;  7'd21: v = 11'd1009; 7'd22: v = 11'd1052; 7'd23: v = 11'd1095;
            7'd24: v = 11'd1137; 7'd25: v = 11'd1179; 7'd26: v = 11'd1219; 7'd27: v = 11'd1259;
            7'd28: v = 11'd1299; 7'd29: v = 11'd1337; 7'd30: v = 11'd1375; 7'd31: v = 11'd1411;
            7'd32: v = 11'd1447; 7'd33: v = 11'd1483; 7'd34: v = 11'd1517; 7'd35: v = 11'd1550;
            7'd36: v = 11'd1582; 7'd37: v = 11'd1614; 7'd38: v = 11'd1644; 7'd39: v = 11'd1674;
            7'd40: v = 11'd1702; 7'd41: v = 11'd1729; 7'd42: v = 11'd1756; 7'd43: v = 11'd1781;
            7'd44: v = 11'd1805; 7'd45: v = 11'd1828; 7'd46: v = 11'd1850; 7'd47: v = 11'd1871;
            7'd48: v = 11'd1891; 7'd49: v = 11'd1910; 7'd50: v = 11'd1927; 7'd51: v = 11'd1944;
            7'd52: v = 11'd1959; 7'd53: v = 11'd1973; 7'd54: v = 11'd1986; 7'd55: v = 11'd1997;
            7'd56: v = 11'd2008; 7'd57: v = 11'd2017; 7'd58: v = 11'd2025; 7'd59: v = 11'd2032;
            7'd60: v = 11'd2037; 7'd61: v = 11'd2041; 7'd62: v = 11'd2045; 7'd63: v = 11'd2046;
            default: v = 11'd2047;
        endcase
        return v;
    endfunction

    // Full-wave lookup folded from the quarter table: odd quadrants mirror, upper half negates.
    function automatic logic signed [ADC_W-1:0] sine_lut(input logic [LUT_AW-1:0] a);
        logic [6:0]       idx;
        logic [ADC_W-1:0] mag;
        idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        mag = {1'b0, quarter_sine(idx)};
        return a[7] ? -$signed(mag) : $signed(mag);
    endfunction
endpackage

// File: rtl/ddc_core_cic.sv
// One CIC decimator arm: clock-rate integrators, comb section evaluated on the shared strobe.
module cic_decim
    import ddc_pkg::*;
#(
    parameter int N  = CIC_N,
    parameter int W  = CIC_W,
    parameter int OW = MIX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          strobe,
    input  logic [OW-1:0] din,
    output logic [OW-1:0] dout
);
    logic [N-1:0][W-1:0] integ_q, integ_d, dly_q, dly_d;
    logic [W-1:0]        comb_out;
    logic                unused_low;

    // Wrap-around arithmetic is intentional: the combs cancel any integrator overflow.
    always_comb begin
        logic [W-1:0] acc;
        integ_d[0] = integ_q[0] + {{(W-OW){din[OW-1]}}, din};
        for (int k = 1; k < N; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        acc = integ_q[N-1];
        for (int k = 0; k < N; k++) begin
            dly_d[k] = strobe ? acc : dly_q[k];
            acc      = acc - dly_q[k];
        end
        comb_out = acc;
    end

    assign dout       = comb_out[W-1 -: OW];
    assign unused_low = ^comb_out[W-OW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q <= '0;
            dly_q   <= '0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
        end
    end
endmodule

// File: rtl/ddc_core.sv
// Digital down-converter: NCO mixing of ADC samples to I/Q, CIC decimation per arm,
// encoder-driven tuning and a two-word ready/ack output port.
module ddc_core
    import ddc_pkg::*;
#(
    parameter logic [PHASE_W-1:0] FTW_INIT    = 32'd0,
    parameter logic [PHASE_W-1:0] STEP_FINE   = 32'd1074,
    parameter logic [PHASE_W-1:0] STEP_COARSE = 32'd107374
) (
    input  logic             ADC_CLK,
    input  logic             RST_N,
    input  logic [ADC_W-1:0] ADC_IN,
    input  logic             ENC_SW,
    input  logic             ENC_DIR,
    input  logic             ENC_CNT,
    input  logic             ENC_CLK,
    input  logic             DATA_ACK,
    output logic [MIX_W-1:0] OUT,
    output logic             DATA_RDY
);
    // Synchroniser bit order: {DATA_ACK, ENC_CLK, ENC_CNT, ENC_DIR, ENC_SW}
    logic [4:0] async_in, meta_q, sync_q;
    logic [2:0] prev_q, rise;
    logic       cnt_rise, push_rise, ack_rise;

    assign async_in  = {DATA_ACK, ENC_CLK, ENC_CNT, ENC_DIR, ENC_SW};
    assign rise      = sync_q[4:2] & ~prev_q;
    assign cnt_rise  = rise[0];
    assign push_rise = rise[1];
    assign ack_rise  = rise[2];

    logic [PHASE_W-1:0] ftw_q, ftw_d, phase_q, phase_d, step;

    always_comb begin
        step  = sync_q[0] ? STEP_COARSE : STEP_FINE;
        ftw_d = ftw_q;
        if (push_rise) begin
            ftw_d = FTW_INIT;
        end else if (cnt_rise) begin
            ftw_d = sync_q[1] ? ftw_q + step : ftw_q - step;
        end
        phase_d = phase_q + ftw_q;
    end

    logic [LUT_AW-1:0]           lut_addr;
    logic [1:0][ADC_W-1:0]       lo_q, lo_d;
    logic [ADC_W-1:0]            x_q, x_d;
    logic [1:0][MIX_W-1:0]       mix_q, mix_d, dec;
    logic [DEC_W-1:0]            cnt_q, cnt_d;
    logic                        strobe;

    // Arm 0 is I (cosine), arm 1 is Q (sine).
    assign lut_addr = phase_q[PHASE_W-1 -: LUT_AW];
    assign lo_d[0]  = sine_lut(lut_addr + LUT_AW'(1 << (LUT_AW - 2)));
    assign lo_d[1]  = sine_lut(lut_addr);
    assign x_d      = {~ADC_IN[ADC_W-1], ADC_IN[ADC_W-2:0]};
    assign cnt_d    = cnt_q + 1'b1;
    assign strobe   = (cnt_q == DEC_W'(CIC_R - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_arm
            logic signed [2*ADC_W-1:0] prod;
            logic                      unused_prod;
            assign prod        = $signed(x_q) * $signed(lo_q[gi]);
            assign mix_d[gi]   = prod[2*ADC_W-2 -: MIX_W];
            assign unused_prod = prod[2*ADC_W-1] ^ (^prod[2*ADC_W-MIX_W-2:0]);

            cic_decim #(.N(CIC_N), .W(CIC_W), .OW(MIX_W)) u_cic (
                .clk    (ADC_CLK),
                .rst_n  (RST_N),
                .strobe (strobe),
                .din    (mix_q[gi]),
                .dout   (dec[gi])
            );
        end
    endgenerate

    logic [MIX_W-1:0] out_q, out_d, hold_q, hold_d;
    logic             rdy_q, rdy_d;
    ptr_e             ptr_q, ptr_d;

    // A fresh decimated pair always takes priority over a pending acknowledge.
    always_comb begin
        out_d  = out_q;
        hold_d = hold_q;
        rdy_d  = rdy_q;
        ptr_d  = ptr_q;
        if (strobe) begin
            out_d  = dec[0];
            hold_d = dec[1];
            rdy_d  = 1'b1;
            ptr_d  = PTR_I;
        end else if (ack_rise && rdy_q) begin
            if (ptr_q == PTR_I) begin
                out_d = hold_q;
                ptr_d = PTR_Q;
            end else begin
                rdy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            ftw_q   <= FTW_INIT;
            phase_q <= '0;
            lo_q    <= '0;
            x_q     <= '0;
            mix_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            hold_q  <= '0;
            rdy_q   <= 1'b0;
            ptr_q   <= PTR_I;
        end else begin
            meta_q  <= async_in;
            sync_q  <= meta_q;
            prev_q  <= sync_q[4:2];
            ftw_q   <= ftw_d;
            phase_q <= phase_d;
            lo_q    <= lo_d;
            x_q     <= x_d;
            mix_q   <= mix_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            hold_q  <= hold_d;
            rdy_q   <= rdy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign OUT      = out_q;
    assign DATA_RDY = rdy_q;
endmodule

// File: tb/tb_ddc_core.sv
// Directed bench for ddc_core: reset, DC mixing, tuning, handshake, overrun and tone rejection.
module tb_ddc_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] adc_in;
    logic        enc_sw, enc_dir, enc_cnt, enc_clk, data_ack;
    logic [15:0] out_w;
    logic        data_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    ddc_core dut (
        .ADC_CLK  (clk),
        .RST_N    (rst_n),
        .ADC_IN   (adc_in),
        .ENC_SW   (enc_sw),
        .ENC_DIR  (enc_dir),
        .ENC_CNT  (enc_cnt),
        .ENC_CLK  (enc_clk),
        .DATA_ACK (data_ack),
        .OUT      (out_w),
        .DATA_RDY (data_rdy)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d checks made", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cnt_pulse();
        enc_cnt = 1'b1; tick(2);
        enc_cnt = 1'b0; tick(2);
    endtask

    task automatic push_pulse();
        enc_clk = 1'b1; tick(2);
        enc_clk = 1'b0; tick(2);
    endtask

    task automatic both_pulse();
        enc_cnt = 1'b1; enc_clk = 1'b1; tick(2);
        enc_cnt = 1'b0; enc_clk = 1'b0; tick(2);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1; tick(2);
        data_ack = 1'b0; tick(2);
    endtask

    task automatic wait_rdy();
        int i;
        i = 0;
        while (data_rdy !== 1'b1 && i < 200) begin
            tick(1);
            i++;
        end
        check("rdy_wait", data_rdy, 1);
    endtask

    task automatic frame(input bit chk, input logic signed [15:0] exp_i,
                         input logic signed [15:0] exp_q);
        wait_rdy();
        if (chk) check("word_i", $signed(out_w), exp_i);
        ack_pulse();
        if (chk) check("word_q", $signed(out_w), exp_q);
        if (chk) check("rdy_after_i", data_rdy, 1);
        ack_pulse();
        if (chk) check("rdy_after_q", data_rdy, 0);
        ack_pulse();
        if (chk) check("extra_ack_rdy", data_rdy, 0);
        if (chk) check("extra_ack_out", $signed(out_w), exp_q);
        $display("frame chk=%0d out=%0d rdy=%0d", chk, $signed(out_w), data_rdy);
    endtask

    initial begin
        rst_n = 1'b0; adc_in = 12'd2;
        enc_sw = 1'b0; enc_dir = 1'b0; enc_cnt = 1'b0; enc_clk = 1'b0; data_ack = 1'b0;
        tick(3);
        check("reset_out", $signed(out_w), 0);
        check("reset_rdy", data_rdy, 0);
        check("reset_ftw", dut.ftw_q, 0);
        rst_n = 1'b1;

        // FTW=0: x=-2046, cos=2047 -> floor(-4188162/128) = -32721, sin=0 -> Q=0
        for (int f = 0; f < 8; f++) frame(f >= 5, -16'sd32721, 16'sd0);

        // Overrun: after one ack the next strobe restarts at I and keeps DATA_RDY high
        wait_rdy();
        ack_pulse();
        check("ovr_first_q", $signed(out_w), 0);
        tick(64);
        check("ovr_rdy", data_rdy, 1);
        check("ovr_refresh_i", $signed(out_w), -32721);
        ack_pulse();
        check("ovr_then_q", $signed(out_w), 0);
        tick(64);
        check("ovr_rdy2", data_rdy, 1);
        check("ovr_refresh_i2", $signed(out_w), -32721);
        ack_pulse();
        ack_pulse();
        check("ovr_drained", data_rdy, 0);

        // Tuning steps and wrap
        enc_sw = 1'b0; enc_dir = 1'b1; tick(4);
        repeat (3) cnt_pulse();
        check("ftw_fine_up3", dut.ftw_q, 3222);
        enc_dir = 1'b0; tick(4);
        cnt_pulse();
        check("ftw_fine_down", dut.ftw_q, 2148);
        push_pulse();
        check("ftw_push", dut.ftw_q, 0);
        enc_sw = 1'b1; tick(4);
        cnt_pulse();
        check("ftw_wrap_down", dut.ftw_q, 64'd4294859922);
        enc_dir = 1'b1; tick(4);
        cnt_pulse();
        check("ftw_wrap_up", dut.ftw_q, 0);
        enc_sw = 1'b0; tick(4);
        cnt_pulse();
        check("ftw_fine_one", dut.ftw_q, 1074);
        both_pulse();
        check("ftw_push_wins", dut.ftw_q, 0);

        // Tone near fs/64 (625 coarse steps, closest coarse multiple to 2^26) with x=0
        adc_in = 12'h800; enc_sw = 1'b1; enc_dir = 1'b1; tick(4);
        repeat (625) cnt_pulse();
        check("ftw_tone", dut.ftw_q, 67108750);
        for (int f = 0; f < 6; f++) frame(f >= 3, 16'sd0, 16'sd0);

        // Reset mid-run with a nonzero tuning word and an unread word pending
        adc_in = 12'd2;
        push_pulse();
        cnt_pulse();
        check("ftw_pre_reset", dut.ftw_q, 107374);
        tick(200);
        check("pre_reset_rdy", data_rdy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out", $signed(out_w), 0);
        check("midrst_rdy", data_rdy, 0);
        check("midrst_ftw", dut.ftw_q, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
